// File: rtl/vc_fifo_pkg.sv
// vc_fifo_pkg: default sizes and width helpers shared by the VC FIFO bank
package vc_fifo_pkg;
   localparam int BW_DEF = 16;
   localparam int DEPTH_DEF = 8;
   localparam int N_VC_DEF = 2;
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction
   function automatic int cnt_w(input int depth);
      return clog2(depth) + 1;
   endfunction
   function automatic int vc_w(input int n_vc);
      return (n_vc > 1) ? clog2(n_vc) : 1;
   endfunction
endpackage

// File: rtl/vc_fifo_chan.sv
// vc_fifo_chan: one circular FIFO with occupancy count and threshold flags
module vc_fifo_chan
   import vc_fifo_pkg::*;
#(
   parameter int BW = BW_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int PTR_W = clog2(DEPTH),
   parameter int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [BW-1:0]    din_i,
   input  logic [CNT_W-1:0] af_thr_i,
   input  logic [CNT_W-1:0] ae_thr_i,
   output logic [BW-1:0]    dout_comb_o,
   output logic             full_o,
   output logic             empty_o,
   output logic             almost_full_o,
   output logic             almost_empty_o
);
   logic [BW-1:0]    mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wr_ok;
   assign full_o = cnt_q == CNT_W'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign almost_full_o = cnt_q >= af_thr_i;
   assign almost_empty_o = cnt_q <= ae_thr_i;
   assign dout_comb_o = mem_q[rptr_q];
   // a full FIFO still accepts a write when the same cycle pops a slot free
   always_comb begin
      wr_ok = push_i && (!full_o || pop_i);
      wptr_d = wr_ok ? wptr_q + PTR_W'(1) : wptr_q;
      rptr_d = pop_i ? rptr_q + PTR_W'(1) : rptr_q;
      cnt_d = (wr_ok && !pop_i) ? cnt_q + CNT_W'(1) : (pop_i && !wr_ok) ? cnt_q - CNT_W'(1) : cnt_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q <= cnt_d;
      end
   end
   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wptr_q] <= din_i;
   end
endmodule

// File: rtl/vc_fifo_bank.sv
// vc_fifo_bank: N_VC FIFOs drained through one arbitrated read port; VC_FIFO_RR_ARB_EN selects round-robin over strict priority
module vc_fifo_bank
   import vc_fifo_pkg::*;
#(
   parameter int BW = BW_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int N_VC = N_VC_DEF,
   parameter int PTR_W = clog2(DEPTH),
   parameter int CNT_W = PTR_W + 1,
   parameter int VC_W = vc_w(N_VC)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_VC-1:0]    wr_en,
   input  logic [N_VC*BW-1:0] wr_data,
   input  logic               rd_req,
   input  logic [CNT_W-1:0]   af_thr,
   input  logic [CNT_W-1:0]   ae_thr,
   output logic [BW-1:0]      data_out,
   output logic               valid_out,
   output logic [VC_W-1:0]    vc_out,
   output logic [N_VC-1:0]    full,
   output logic [N_VC-1:0]    empty,
   output logic [N_VC-1:0]    almost_full,
   output logic [N_VC-1:0]    almost_empty,
   output logic [N_VC-1:0]    error
);
   logic [BW-1:0]   dout [N_VC];
   logic [N_VC-1:0] pop;
   logic [VC_W-1:0] gnt;
   logic            grant;
   logic [BW-1:0]   data_q, data_d;
   logic            valid_q, valid_d;
   logic [VC_W-1:0] vc_q, vc_d;
   logic [N_VC-1:0] err_q, err_d;
   for (genvar i = 0; i < N_VC; i++) begin : g_chan
      vc_fifo_chan #(.BW(BW), .DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) u_chan (
         .clk(clk),
         .reset(reset),
         .push_i(wr_en[i]),
         .pop_i(pop[i]),
         .din_i(wr_data[i*BW +: BW]),
         .af_thr_i(af_thr),
         .ae_thr_i(ae_thr),
         .dout_comb_o(dout[i]),
         .full_o(full[i]),
         .empty_o(empty[i]),
         .almost_full_o(almost_full[i]),
         .almost_empty_o(almost_empty[i])
      );
   end
`ifdef VC_FIFO_RR_ARB_EN
   // rr_q holds the VC the next search starts from (one past the last grant)
   logic [VC_W-1:0] rr_q, rr_d;
   always_comb begin
      gnt = '0;
      for (int k = N_VC - 1; k >= 0; k--)
         if (!empty[(int'(rr_q) + k) % N_VC]) gnt = VC_W'((int'(rr_q) + k) % N_VC);
      rr_d = (rd_req && !(&empty)) ? VC_W'((int'(gnt) + 1) % N_VC) : rr_q;
   end
   always_ff @(posedge clk) begin
      rr_q <= reset ? '0 : rr_d;
   end
`else
   always_comb begin
      gnt = '0;
      for (int k = 0; k < N_VC; k++)
         if (!empty[k]) gnt = VC_W'(k);
   end
`endif
   always_comb begin
      grant = rd_req && !(&empty);
      pop = '0;
      for (int k = 0; k < N_VC; k++)
         pop[k] = grant && (gnt == VC_W'(k));
      data_d = grant ? dout[gnt] : data_q;
      vc_d = grant ? gnt : vc_q;
      valid_d = grant;
      err_d = err_q | (wr_en & full & ~pop);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q <= '0;
         valid_q <= 1'b0;
         vc_q <= '0;
         err_q <= '0;
      end else begin
         data_q <= data_d;
         valid_q <= valid_d;
         vc_q <= vc_d;
         err_q <= err_d;
      end
   end
   assign data_out = data_q;
   assign valid_out = valid_q;
   assign vc_out = vc_q;
   assign error = err_q;
endmodule

// File: tb/tb_vc_fifo_bank.sv
// tb_vc_fifo_bank: queue-based reference model with scoreboard for vc_fifo_bank
module tb_vc_fifo_bank;
   localparam int BW = 16;
   localparam int DEPTH = 8;
   localparam int N_VC = 2;
   localparam int CNT_W = 4;
   localparam int VC_W = 1;
   typedef struct packed {
      logic [BW-1:0]   d;
      logic [VC_W-1:0] v;
   } exp_t;
   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic [N_VC-1:0]    wr_en = '0;
   logic [N_VC*BW-1:0] wr_data = '0;
   logic               rd_req = 1'b0;
   logic [CNT_W-1:0]   af_thr = 4'd6;
   logic [CNT_W-1:0]   ae_thr = 4'd1;
   logic [BW-1:0]      data_out;
   logic               valid_out;
   logic [VC_W-1:0]    vc_out;
   logic [N_VC-1:0]    full, empty, almost_full, almost_empty, error;
   int                 total = 0;
   int                 bad = 0;
   bit                 armed = 0;
   logic [BW-1:0]      mq [N_VC][$];
   bit [N_VC-1:0]      merr = '0;
   int                 mrr = 0;
   exp_t               sb [$];
   always #5 clk = ~clk;
   vc_fifo_bank dut (
      .clk(clk),
      .reset(reset),
      .wr_en(wr_en),
      .wr_data(wr_data),
      .rd_req(rd_req),
      .af_thr(af_thr),
      .ae_thr(ae_thr),
      .data_out(data_out),
      .valid_out(valid_out),
      .vc_out(vc_out),
      .full(full),
      .empty(empty),
      .almost_full(almost_full),
      .almost_empty(almost_empty),
      .error(error)
   );
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic step(input logic r, input logic [N_VC-1:0] we, input logic [N_VC*BW-1:0] wd, input logic rd);
      bit [N_VC-1:0] ef, ee, eaf, eae, fpre;
      bit            gr;
      int            g;
      exp_t          e;
      @(negedge clk);
      if (armed) begin
         for (int i = 0; i < N_VC; i++) begin
            ef[i] = mq[i].size() == DEPTH;
            ee[i] = mq[i].size() == 0;
            eaf[i] = mq[i].size() >= int'(af_thr);
            eae[i] = mq[i].size() <= int'(ae_thr);
         end
         chk("full", 32'(full), 32'(ef));
         chk("empty", 32'(empty), 32'(ee));
         chk("almost_full", 32'(almost_full), 32'(eaf));
         chk("almost_empty", 32'(almost_empty), 32'(eae));
         chk("error", 32'(error), 32'(merr));
      end
      reset = r;
      wr_en = we;
      wr_data = wd;
      rd_req = rd;
      if (r) begin
         for (int i = 0; i < N_VC; i++) mq[i].delete();
         merr = '0;
         mrr = 0;
         armed = 1;
      end else begin
         for (int i = 0; i < N_VC; i++) fpre[i] = mq[i].size() == DEPTH;
         gr = 0;
         g = 0;
`ifdef VC_FIFO_RR_ARB_EN
         for (int k = 0; k < N_VC && !gr; k++)
            if (mq[(mrr + k) % N_VC].size() > 0) begin
               gr = 1;
               g = (mrr + k) % N_VC;
            end
`else
         for (int k = N_VC - 1; k >= 0 && !gr; k--)
            if (mq[k].size() > 0) begin
               gr = 1;
               g = k;
            end
`endif
         gr = gr && rd;
         if (gr) begin
            e.d = mq[g].pop_front();
            e.v = VC_W'(g);
            sb.push_back(e);
            mrr = (g + 1) % N_VC;
         end
         for (int i = 0; i < N_VC; i++)
            if (we[i]) begin
               if (!fpre[i] || (gr && g == i)) mq[i].push_back(wd[i*BW +: BW]);
               else merr[i] = 1;
            end
      end
   endtask
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (valid_out === 1'b1) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_valid: got vc=%0d data=%h want no output at %0t", vc_out, data_out, $time);
            end else begin
               e = sb.pop_front();
               chk("data_out", 32'(data_out), 32'(e.d));
               chk("vc_out", 32'(vc_out), 32'(e.v));
            end
         end
      end
   end
   initial begin
      step(1, '0, '0, 0);
      step(1, '0, '0, 0);
      for (int i = 0; i < 5; i++) step(0, 2'b01, 32'(10 + i), 0);
      repeat (5) step(0, '0, '0, 1);
      repeat (3) step(0, '0, '0, 0);
      for (int i = 0; i < 8; i++) step(0, 2'b10, {16'(32'h100 + i), 16'h0}, 0);
      step(0, 2'b10, {16'h00FF, 16'h0}, 0);
      repeat (10) step(0, '0, '0, 1);
      for (int i = 0; i < 8; i++) step(0, 2'b01, 32'(32'h20 + i), 0);
      repeat (9) step(0, '0, '0, 1);
      for (int i = 0; i < 3; i++) step(0, 2'b11, {16'(32'h200 + i), 16'(32'h300 + i)}, 0);
      repeat (8) step(0, '0, '0, 1);
      for (int i = 0; i < 8; i++) step(0, 2'b01, 32'(32'h40 + i), 0);
      repeat (20) step(0, 2'b01, 32'h55, 1);
      repeat (10) step(0, '0, '0, 1);
      for (int i = 0; i < 4; i++) step(0, 2'b11, {16'(32'h600 + i), 16'(32'h700 + i)}, 0);
      step(1, 2'b11, 32'hDEADBEEF, 1);
      repeat (3) step(0, '0, '0, 1);
      for (int n = 0; n < 3000; n++) begin
         if (n % 100 == 0) begin
            af_thr = 4'($urandom_range(0, 10));
            ae_thr = 4'($urandom_range(0, 10));
         end
         step($urandom_range(0, 199) == 0, 2'($urandom), {16'($urandom), 16'($urandom)},
              $urandom_range(0, 9) < (((n / 400) % 2 == 0) ? 4 : 9));
      end
      repeat (20) step(0, '0, '0, 1);
      repeat (2) step(0, '0, '0, 0);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
